apb_dp_mem_p: RTL and testbench

Parametrised APB4 completer memory with an independent native read port. Generalises the team's fixed-geometry APB memory slave: configurable data width, depth, per-direction wait states and read-only window, plus address-range and protocol-error detection. Port A sits on the APB fabric for CPU access. Port B is a single-cycle synchronous read port for a local consumer (DMA/stream engine).

---
 rtl/apb_pkg.sv | 34 +++
 rtl/dp_ram_core.sv | 48 ++++
 rtl/apb_dp_mem_p.sv | 156 +++++++++++++++
 tb/tb_apb_dp_mem_p.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB completer memory with a native read port.
// Imported by the top level and the RAM core so both agree on enum encodings and widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_fsm_enum;

  typedef enum logic [1:0] {
    OKAY,
    SLVERR_RANGE,
    SLVERR_RO,
    SLVERR_PROT
  } apb_resp_e;

  localparam int unsigned WAIT_W   = 4;
  localparam int unsigned WAIT_MAX = 15;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Bits needed to select one byte lane of a data word.
  function automatic int unsigned lane_sel_width(input int unsigned data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 1;
  endfunction

  function automatic int unsigned index_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Word-organised RAM: byte-enabled write port, combinational read port A,
// registered read port B. Port B sees pre-write contents when it collides with a write.
module dp_ram_core
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [index_width(DEPTH)-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]               wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0]   wstrb,
  input  logic [index_width(DEPTH)-1:0]       a_addr,
  output logic [DATA_WIDTH-1:0]               a_rdata,
  input  logic                                b_en,
  input  logic                                b_zero,
  input  logic [index_width(DEPTH)-1:0]       b_addr,
  output logic [DATA_WIDTH-1:0]               b_rdata
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the port B output register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign a_rdata = mem[a_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      b_rdata <= '0;
    end else if (b_en) begin
      b_rdata <= b_zero ? '0 : mem[b_addr];
    end
  end

endmodule

// File: rtl/apb_dp_mem_p.sv
// APB4 completer front end: transfer FSM, per-direction wait counter and error decode,
// wrapped around the dual-port RAM core. Port B is a free-running local read port.
module apb_dp_mem_p
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 3,
  parameter int unsigned RO_BASE    = 1,
  parameter int unsigned RO_LAST    = 14
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      b_en,
  input  logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [DATA_WIDTH-1:0]     b_rdata,
  output logic                      b_err
);

  localparam int unsigned IDX_W = index_width(DEPTH);

  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] RO_BASE_L = (ADDR_WIDTH+1)'(RO_BASE);
  localparam logic [ADDR_WIDTH:0] RO_LAST_L = (ADDR_WIDTH+1)'(RO_LAST);
  localparam bit                  RO_EN     = (RO_LAST >= RO_BASE);

  localparam logic [WAIT_W-1:0] RD_WAIT_L = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_WAIT_L = WAIT_W'(WR_WAIT);

  generate
    if ((DATA_WIDTH == 0) || (DATA_WIDTH % 8 != 0)) begin : g_bad_width
      $fatal(1, "apb_dp_mem_p: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if ((DEPTH == 0) || (64'(DEPTH) > (64'd1 << ADDR_WIDTH))) begin : g_bad_depth
      $fatal(1, "apb_dp_mem_p: DEPTH must be between 1 and 2**ADDR_WIDTH");
    end
    if ((RD_WAIT > WAIT_MAX) || (WR_WAIT > WAIT_MAX)) begin : g_bad_wait
      $fatal(1, "apb_dp_mem_p: RD_WAIT and WR_WAIT must not exceed 15");
    end
  endgenerate

  apb_fsm_enum         state;
  logic [WAIT_W-1:0]   wait_cnt;
  apb_resp_e           resp;
  logic                in_range;
  logic                in_ro;
  logic                b_in_range;
  logic                is_err;
  logic                in_access;
  logic                cnt_zero;
  logic                commit;
  logic [DATA_WIDTH-1:0] a_rdata;

  assign in_range   = ({1'b0, PADDR} < DEPTH_L);
  assign b_in_range = ({1'b0, b_addr} < DEPTH_L);
  assign in_ro      = RO_EN && ({1'b0, PADDR} >= RO_BASE_L) && ({1'b0, PADDR} <= RO_LAST_L);

  // Error class of the transfer currently held on the bus; only meaningful in ACCESS.
  always_comb begin
    resp = OKAY;
    if (!in_range) begin
      resp = SLVERR_RANGE;
    end else if (PWRITE && in_ro) begin
      resp = SLVERR_RO;
    end else if (!PWRITE && (PSTRB != '0)) begin
      resp = SLVERR_PROT;
    end
  end

  assign is_err    = (resp != OKAY);
  assign in_access = (state == ACCESS);
  assign cnt_zero  = (wait_cnt == '0);

  assign PREADY  = in_access && (is_err || cnt_zero);
  assign PSLVERR = in_access && is_err;
  assign PRDATA  = (in_access && !is_err && !PWRITE && cnt_zero) ? a_rdata : '0;

  // Reset in the completing cycle must still suppress the write.
  assign commit = in_access && !is_err && PWRITE && cnt_zero && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            state    <= ACCESS;
            wait_cnt <= PWRITE ? WR_WAIT_L : RD_WAIT_L;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            state    <= PSEL ? SETUP : IDLE;
            wait_cnt <= '0;
          end else if (!PSEL) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      b_err <= 1'b0;
    end else if (b_en) begin
      b_err <= !b_in_range;
    end
  end

  dp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (PCLK),
    .rst     (PRESET),
    .we      (commit),
    .waddr   (PADDR[IDX_W-1:0]),
    .wdata   (PWDATA),
    .wstrb   (PSTRB),
    .a_addr  (PADDR[IDX_W-1:0]),
    .a_rdata (a_rdata),
    .b_en    (b_en),
    .b_zero  (!b_in_range),
    .b_addr  (b_addr[IDX_W-1:0]),
    .b_rdata (b_rdata)
  );

endmodule

// File: tb/tb_apb_dp_mem_p.sv
// Directed bench for apb_dp_mem_p (DEPTH=512, other parameters default):
// APB latencies, strobes, error responses, port B collision, reset and abort mid-transfer.
module tb_apb_dp_mem_p;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        b_en;
  logic [9:0]  b_addr;
  logic [31:0] b_rdata;
  logic        b_err;

  int checks;
  int failures;

  logic [31:0] rd;
  logic        er;
  int          lat;

  apb_dp_mem_p #(
    .DEPTH (512)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .b_en    (b_en),
    .b_addr  (b_addr),
    .b_rdata (b_rdata),
    .b_err   (b_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One complete APB transfer from IDLE; lat counts ACCESS cycles up to and including PREADY.
  // With collide set, a port B read of the same word is issued on the completing edge.
  task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic collide,
                               output logic [31:0] rdata, output logic err, output int lcnt);
    bit done;
    done  = 0;
    lcnt  = 0;
    rdata = '0;
    err   = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    while (!done && lcnt < 40) begin
      @(posedge PCLK); #1;
      lcnt++;
      @(negedge PCLK);
      if (PREADY) begin
        done  = 1;
        rdata = PRDATA;
        err   = PSLVERR;
        if (collide) begin
          b_en   = 1'b1;
          b_addr = addr;
        end
      end
    end
    checkOutput("xfer_done", 64'(done), 64'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0; b_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; b_en = 1'b0; b_addr = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    checkOutput("rst_pready",  64'(PREADY),  64'd0);
    checkOutput("rst_pslverr", 64'(PSLVERR), 64'd0);
    checkOutput("rst_prdata",  64'(PRDATA),  64'd0);
    checkOutput("rst_b_rdata", 64'(b_rdata), 64'd0);
    checkOutput("rst_b_err",   64'(b_err),   64'd0);

    // Full-word write then read: write waits 3, read waits 1.
    applyStimulus(1'b1, 10'h020, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat);
    checkOutput("wr20_lat", 64'(lat), 64'd4);
    checkOutput("wr20_err", 64'(er),  64'd0);
    applyStimulus(1'b0, 10'h020, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("rd20_lat",  64'(lat), 64'd2);
    checkOutput("rd20_err",  64'(er),  64'd0);
    checkOutput("rd20_data", 64'(rd),  64'h00000000DEADBEEF);

    // Lanes 0 and 2 only.
    applyStimulus(1'b1, 10'h020, 32'h11223344, 4'h5, 1'b0, rd, er, lat);
    checkOutput("strb_wr_err", 64'(er), 64'd0);
    applyStimulus(1'b0, 10'h020, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("strb_rd_data", 64'(rd), 64'h00000000DE22BE44);

    // Read-only window 1..14 and its neighbours.
    applyStimulus(1'b1, 10'h005, 32'hA5A5A5A5, 4'hF, 1'b0, rd, er, lat);
    checkOutput("ro5_lat",   64'(lat), 64'd1);
    checkOutput("ro5_err",   64'(er),  64'd1);
    checkOutput("ro5_prd",   64'(rd),  64'd0);
    applyStimulus(1'b0, 10'h005, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("ro5_rd_err",     64'(er),               64'd0);
    checkOutput("ro5_not_written", 64'(rd == 32'hA5A5A5A5), 64'd0);
    applyStimulus(1'b1, 10'h00E, 32'h0000000E, 4'hF, 1'b0, rd, er, lat);
    checkOutput("ro_last_err", 64'(er), 64'd1);
    applyStimulus(1'b1, 10'h00F, 32'h0F0F0F0F, 4'hF, 1'b0, rd, er, lat);
    checkOutput("ro_after_lat", 64'(lat), 64'd4);
    checkOutput("ro_after_err", 64'(er),  64'd0);
    applyStimulus(1'b1, 10'h000, 32'h00C0FFEE, 4'hF, 1'b0, rd, er, lat);
    checkOutput("ro_before_err", 64'(er), 64'd0);
    applyStimulus(1'b0, 10'h00F, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("ro_after_data", 64'(rd), 64'h000000000F0F0F0F);
    applyStimulus(1'b0, 10'h000, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("ro_before_data", 64'(rd), 64'h0000000000C0FFEE);

    // Last in-range word and out-of-range / protocol errors.
    applyStimulus(1'b1, 10'h1FF, 32'h600DCAFE, 4'hF, 1'b0, rd, er, lat);
    checkOutput("last_wr_err", 64'(er), 64'd0);
    applyStimulus(1'b0, 10'h1FF, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("last_rd_data", 64'(rd), 64'h00000000600DCAFE);
    applyStimulus(1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("oor3ff_lat", 64'(lat), 64'd1);
    checkOutput("oor3ff_err", 64'(er),  64'd1);
    checkOutput("oor3ff_prd", 64'(rd),  64'd0);
    applyStimulus(1'b0, 10'h200, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("oor200_err", 64'(er), 64'd1);
    applyStimulus(1'b1, 10'h200, 32'h12121212, 4'hF, 1'b0, rd, er, lat);
    checkOutput("oor200_wr_lat", 64'(lat), 64'd1);
    checkOutput("oor200_wr_err", 64'(er),  64'd1);
    applyStimulus(1'b0, 10'h020, 32'h0, 4'h1, 1'b0, rd, er, lat);
    checkOutput("prot_lat", 64'(lat), 64'd1);
    checkOutput("prot_err", 64'(er),  64'd1);
    checkOutput("prot_prd", 64'(rd),  64'd0);

    // Port B read colliding with the commit edge returns the old word.
    applyStimulus(1'b1, 10'h020, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, lat);
    checkOutput("coll_old",   64'(b_rdata), 64'h00000000DE22BE44);
    checkOutput("coll_b_err", 64'(b_err),   64'd0);
    b_en = 1'b1; b_addr = 10'h020;
    @(posedge PCLK); #1;
    checkOutput("pb_new", 64'(b_rdata), 64'h00000000CAFEF00D);
    b_addr = 10'h200;
    @(posedge PCLK); #1;
    checkOutput("pb_oor_data", 64'(b_rdata), 64'd0);
    checkOutput("pb_oor_err",  64'(b_err),   64'd1);
    b_addr = 10'h020;
    @(posedge PCLK); #1;
    b_en = 1'b0; b_addr = 10'h200;
    @(posedge PCLK); #1;
    checkOutput("pb_hold_data", 64'(b_rdata), 64'h00000000CAFEF00D);
    checkOutput("pb_hold_err",  64'(b_err),   64'd0);

    applyStimulus(1'b1, 10'h030, 32'h0BADF00D, 4'hF, 1'b0, rd, er, lat);
    checkOutput("w30_err", 64'(er), 64'd0);

    // Reset lands in the completing ACCESS cycle of a write to 0x30.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h030; PWDATA = 32'h12345678; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge PCLK); #1;
    end
    @(negedge PCLK);
    checkOutput("rst_mid_ready", 64'(PREADY), 64'd1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
    @(negedge PCLK);
    checkOutput("rst_mid_pready",  64'(PREADY),  64'd0);
    checkOutput("rst_mid_pslverr", 64'(PSLVERR), 64'd0);
    checkOutput("rst_mid_prdata",  64'(PRDATA),  64'd0);
    checkOutput("rst_mid_b_rdata", 64'(b_rdata), 64'd0);
    checkOutput("rst_mid_b_err",   64'(b_err),   64'd0);
    applyStimulus(1'b0, 10'h030, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("rst_mid_rd_lat",  64'(lat), 64'd2);
    checkOutput("rst_mid_rd_data", 64'(rd),  64'h000000000BADF00D);

    // PSEL dropped in the second ACCESS cycle of a write to 0x30.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h030; PWDATA = 32'h55AA55AA; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge PCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    checkOutput("abort_ready_mid", 64'(PREADY), 64'd0);
    @(posedge PCLK); #1;
    PWRITE = 1'b0; PSTRB = '0;
    @(negedge PCLK);
    checkOutput("abort_pready",  64'(PREADY),  64'd0);
    checkOutput("abort_pslverr", 64'(PSLVERR), 64'd0);
    checkOutput("abort_prdata",  64'(PRDATA),  64'd0);
    applyStimulus(1'b0, 10'h030, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("abort_rd_lat",  64'(lat), 64'd2);
    checkOutput("abort_rd_data", 64'(rd),  64'h000000000BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
